sar_search_ctrl: RTL and testbench



---
 rtl/sar_search_ctrl.sv | 134 +++++++++++++
 tb/tb_sar_search_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// ============================================================================
// sar_search_ctrl : MSB-first successive-approximation search controller that
// resolves a hidden WIDTH-bit target through an external magnitude comparator.
// Optional: `SAR_SEARCH_EARLY_EXIT_EN finishes early on an equal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRIAL = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_MSB = C_ONE << (WIDTH-1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_err_q, flag_err_d;

  logic             flags_legal;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      guess_q    <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      flag_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      guess_q    <= guess_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      flag_err_q <= flag_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    idx_d      = idx_q;
    result_d   = result_q;
    flag_err_d = flag_err_q;
    bit_mask   = C_ONE << idx_q;
    trial      = guess_q;

    case ({cmp_gt, cmp_eq, cmp_lt})
      3'b100, 3'b010, 3'b001: flags_legal = 1'b1;
      default:                flags_legal = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_TRIAL;
          guess_d    = C_MSB;
          idx_d      = IDX_W'(WIDTH-1);
          flag_err_d = 1'b0;
        end
      end

      S_TRIAL: begin
        if (!flags_legal) begin
          flag_err_d = 1'b1;
          result_d   = '0;
          guess_d    = '0;
          state_d    = S_DONE;
        end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        else if (cmp_eq) begin
          result_d = guess_q;
          guess_d  = '0;
          state_d  = S_DONE;
        end
`endif
        else begin
          // Without early exit an equal flag keeps the bit, same as less-than.
          if (cmp_gt) begin
            trial = guess_q & ~bit_mask;
          end
          if (idx_q != '0) begin
            guess_d = trial | (bit_mask >> 1);
            idx_d   = idx_q - 1'b1;
          end else begin
            result_d = trial;
            guess_d  = '0;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == S_TRIAL);
    done     = (state_q == S_DONE);
    guess    = guess_q;
    result   = result_q;
    flag_err = flag_err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
// ============================================================================
// tb_sar_search_ctrl : self-checking bench; models the comparator and derives
// expected trial values from target-prefix arithmetic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sar_search_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cmp_gt, cmp_eq, cmp_lt;
  logic [W-1:0] guess;
  logic         busy, done;
  logic [W-1:0] result;
  logic         flag_err;

  logic [W-1:0] target;
  logic         force_ill;
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cmp_gt = force_ill ? 1'b1 : (guess > target);
  assign cmp_lt = force_ill ? 1'b1 : (guess < target);
  assign cmp_eq = force_ill ? 1'b0 : (guess == target);

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmp_gt   (cmp_gt),
    .cmp_eq   (cmp_eq),
    .cmp_lt   (cmp_lt),
    .guess    (guess),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag_err (flag_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trial i keeps the target's top i bits and probes the next bit down.
  function automatic logic [W-1:0] exp_guess(input int t, input int i);
    int hi;
    hi = ((1 << W) - 1) ^ ((1 << (W - i)) - 1);
    return W'((t & hi) | (1 << (W - 1 - i)));
  endfunction

  function automatic int exp_trials(input int t);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    for (int i = 0; i < W; i++) begin
      if (int'(exp_guess(t, i)) == t) return i + 1;
    end
`endif
    return W;
  endfunction

  task automatic do_search(input int t, input bit noise, output int k1);
    int n;
    target = W'(t);
    start  = 1'b1;
    tick();
    k1    = cyc;
    start = 1'b0;
    n     = exp_trials(t);
    for (int i = 0; i < n; i++) begin
      if (noise) start = 1'($urandom_range(0, 1));
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || flag_err !== 1'b0) begin
        miscompares++;
        $display("FAIL trial_status t=%0d i=%0d busy=%b done=%b err=%b want 1/0/0", t, i, busy, done, flag_err);
      end
      vectors++;
      if (guess !== exp_guess(t, i)) begin
        miscompares++;
        $display("FAIL trial_guess t=%0d i=%0d got %0d want %0d", t, i, guess, exp_guess(t, i));
      end
      tick();
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || flag_err !== 1'b0) begin
      miscompares++;
      $display("FAIL done_status t=%0d done=%b busy=%b err=%b want 1/0/0", t, done, busy, flag_err);
    end
    vectors++;
    if (result !== W'(t)) begin
      miscompares++;
      $display("FAIL result t=%0d got %0d want %0d", t, result, t);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== W'(t)) begin
      miscompares++;
      $display("FAIL after_done t=%0d done=%b busy=%b result=%0d want 0/0/%0d", t, done, busy, result, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({guess, busy, done, result, flag_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state guess=%0d busy=%b done=%b result=%0d err=%b want all 0", guess, busy, done, result, flag_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_target11();
    int k;
    do_search(11, 1'b0, k);
  endtask

  task automatic test_edges();
    int k;
    do_search(0, 1'b0, k);
    do_search(15, 1'b0, k);
  endtask

  task automatic test_eq_handling();
    int k;
    do_search(8, 1'b1, k);
  endtask

  task automatic test_illegal_flags();
    int k;
    target = W'(5);
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (guess !== W'(4) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_setup guess=%0d busy=%b want 4/1", guess, busy);
    end
    force_ill = 1'b1;
    tick();
    force_ill = 1'b0;
    vectors++;
    if (done !== 1'b1 || flag_err !== 1'b1 || result !== '0 || guess !== '0) begin
      miscompares++;
      $display("FAIL illegal_done done=%b err=%b result=%0d guess=%0d want 1/1/0/0", done, flag_err, result, guess);
    end
    tick();
    vectors++;
    if (flag_err !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_hold err=%b done=%b want 1/0", flag_err, done);
    end
    do_search(5, 1'b0, k);
  endtask

  task automatic test_reset_mid();
    int k;
    target = W'(9);
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b1 || guess !== exp_guess(9, 2)) begin
      miscompares++;
      $display("FAIL mid_setup busy=%b guess=%0d want 1/%0d", busy, guess, exp_guess(9, 2));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({guess, busy, done, result, flag_err} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset guess=%0d busy=%b done=%b result=%0d err=%b want all 0", guess, busy, done, result, flag_err);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_no_done done=%b want 0", done);
    end
    do_search(6, 1'b0, k);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 20; n++) begin
      do_search(int'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)), k);
    end
  endtask

  task automatic test_back_to_back();
    int k, prev_k;
    prev_k = 0;
    for (int t = 0; t < (1 << W); t++) begin
      do_search(t, 1'b0, k);
      if (t > 0) begin
        vectors++;
        if (k - prev_k !== exp_trials(t - 1) + 2) begin
          miscompares++;
          $display("FAIL period t=%0d got %0d want %0d", t, k - prev_k, exp_trials(t - 1) + 2);
        end
      end
      prev_k = k;
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    force_ill = 1'b0;
    target    = '0;
    test_reset();
    test_target11();
    test_edges();
    test_eq_handling();
    test_illegal_flags();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
